// File: rtl/puf_pkg.sv
// Shared types, constants and helpers for the ring-oscillator PUF sequencer.
// The LFSR step and select derivation live here so the sequencer and its LFSR agree.
package puf_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 12;

    // Feedback taps at bits 7, 5, 4 and 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] LAST_ROUND = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SAMPLE,
        S_DONE
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    // Oscillator B must never be the same ring as oscillator A
    function automatic logic [2:0] pick_b(input logic [7:0] v);
        return (v[5:3] == v[2:0]) ? (v[2:0] ^ 3'b001) : v[5:3];
    endfunction

endpackage

// File: rtl/puf_lfsr8.sv
// 8-bit Fibonacci LFSR holding the challenge; a load seeds and steps in one edge.
// stepped shows the value the register takes on the next load/step edge.
module puf_lfsr8
    import puf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] stepped
);

    logic [7:0] value;
    logic [7:0] base;

    // An all-zero seed would lock the LFSR, so substitute 8'h01
    always_comb begin
        base = value;
        if (load) begin
            base = (seed == 8'h00) ? 8'h01 : seed;
        end
        stepped = lfsr_next(base);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 8'h01;
        end else if (load || step) begin
            value <= stepped;
        end
    end

endmodule

// File: rtl/puf_sequencer.sv
// Eight-round ring-oscillator PUF sequencer: clear, run a window, compare counts,
// shift one response bit per round; the challenge LFSR picks the oscillator pair.
module puf_sequencer
    import puf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       chall_in,
    input  logic [WIN_W-1:0] window,
    input  logic [CNT_W-1:0] cnt_a,
    input  logic [CNT_W-1:0] cnt_b,
    output logic             osc_en,
    output logic             cnt_clr,
    output logic [2:0]       sel_a,
    output logic [2:0]       sel_b,
    output logic [7:0]       response,
    output logic             ready,
    output logic             busy
);

    state_t           state;
    logic [WIN_W-1:0] win_len;
    logic [WIN_W-1:0] win_cnt;
    logic [3:0]       round;
    logic             start;
    logic             lfsr_step;
    logic [7:0]       stepped;

    assign start = en && ((state == S_IDLE) || (state == S_DONE));
    assign lfsr_step = (state == S_SAMPLE) && (round != LAST_ROUND);

    puf_lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start),
        .step    (lfsr_step),
        .seed    (chall_in),
        .stepped (stepped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            osc_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            sel_a    <= 3'd0;
            sel_b    <= 3'd0;
            response <= 8'h00;
            ready    <= 1'b0;
            busy     <= 1'b0;
            round    <= 4'd0;
            win_len  <= '0;
            win_cnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (en) begin
                        state    <= S_CLEAR;
                        cnt_clr  <= 1'b1;
                        osc_en   <= 1'b0;
                        busy     <= 1'b1;
                        ready    <= 1'b0;
                        response <= 8'h00;
                        round    <= 4'd0;
                        win_len  <= (window == '0) ? WIN_W'(1) : window;
                        sel_a    <= stepped[2:0];
                        sel_b    <= pick_b(stepped);
                    end
                end
                S_CLEAR: begin
                    state   <= S_RUN;
                    cnt_clr <= 1'b0;
                    osc_en  <= 1'b1;
                    win_cnt <= win_len;
                end
                S_RUN: begin
                    win_cnt <= win_cnt - 1'b1;
                    if (win_cnt == WIN_W'(1)) begin
                        state  <= S_SAMPLE;
                        osc_en <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    response <= {response[6:0], (cnt_a > cnt_b)};
                    round    <= round + 4'd1;
                    if (round == LAST_ROUND) begin
                        state <= S_DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= S_CLEAR;
                        cnt_clr <= 1'b1;
                        sel_a   <= stepped[2:0];
                        sel_b   <= pick_b(stepped);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_sequencer.sv
// Directed bench for puf_sequencer: full sequences, window edge cases, reset
// mid-run, ignored starts while busy, and restart from DONE.
module tb_puf_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  chall_in;
    logic [11:0] window;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic        osc_en;
    logic        cnt_clr;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [7:0]  response;
    logic        ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Selects per round for seed 8'h01, stepped by hand:
    // 02, 04, 08, 11, 23, 47, 8E, 1C
    logic [2:0] ea [8] = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd7, 3'd6, 3'd4};
    logic [2:0] eb [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd3};

    puf_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .chall_in (chall_in),
        .window   (window),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .osc_en   (osc_en),
        .cnt_clr  (cnt_clr),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .response (response),
        .ready    (ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " osc_en"}, 32'(osc_en), 32'd0);
        chk({tag, " cnt_clr"}, 32'(cnt_clr), 32'd0);
        chk({tag, " sel_a"}, 32'(sel_a), 32'd0);
        chk({tag, " sel_b"}, 32'(sel_b), 32'd0);
        chk({tag, " response"}, 32'(response), 32'h00);
        chk({tag, " ready"}, 32'(ready), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Start a sequence and check every cycle up to the first DONE cycle.
    // Round r, phase p: p=0 CLEAR, 1..weff RUN, weff+1 SAMPLE.
    task automatic run_seq(input string name, input logic [7:0] ch,
                           input logic [11:0] w_in, input int weff,
                           input logic [15:0] ca, input logic [15:0] cb,
                           input bit parity, input logic [7:0] exp_resp,
                           input int glitch_k);
        int n;
        int r;
        int p;
        logic [2:0] a0;
        logic [2:0] b0;
        a0 = 3'd0;
        b0 = 3'd0;
        cnt_a = ca;
        cnt_b = cb;
        en = 1'b1;
        chall_in = ch;
        window = w_in;
        step_clk();
        en = 1'b0;
        chall_in = 8'h84;
        window = 12'd0;
        n = 8 * (weff + 2);
        for (int k = 0; k < n; k++) begin
            if (k > 0) step_clk();
            r = k / (weff + 2);
            p = k % (weff + 2);
            en = (k == glitch_k);
            if (parity) cnt_a = (r % 2 == 0) ? 16'd200 : 16'd100;
            chk($sformatf("%s cnt_clr r%0d p%0d", name, r, p),
                32'(cnt_clr), 32'(p == 0));
            chk($sformatf("%s osc_en r%0d p%0d", name, r, p),
                32'(osc_en), 32'(p >= 1 && p <= weff));
            chk($sformatf("%s busy r%0d p%0d", name, r, p),
                32'(busy), 32'd1);
            chk($sformatf("%s ready r%0d p%0d", name, r, p),
                32'(ready), 32'd0);
            chk($sformatf("%s sel_a r%0d p%0d", name, r, p),
                32'(sel_a), 32'(ea[r]));
            chk($sformatf("%s sel_b r%0d p%0d", name, r, p),
                32'(sel_b), 32'(eb[r]));
            chk($sformatf("%s sel_diff r%0d p%0d", name, r, p),
                32'(sel_a != sel_b), 32'd1);
            if (p == 0) begin
                a0 = sel_a;
                b0 = sel_b;
            end else begin
                chk($sformatf("%s sel_stable r%0d p%0d", name, r, p),
                    32'(sel_a == a0 && sel_b == b0), 32'd1);
            end
        end
        step_clk();
        en = 1'b0;
        chk({name, " done ready"}, 32'(ready), 32'd1);
        chk({name, " done busy"}, 32'(busy), 32'd0);
        chk({name, " done response"}, 32'(response), 32'(exp_resp));
        chk({name, " done osc_en"}, 32'(osc_en), 32'd0);
        chk({name, " done cnt_clr"}, 32'(cnt_clr), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        chall_in = 8'h00;
        window = 12'd4;
        cnt_a = 16'd0;
        cnt_b = 16'd0;

        // Reset with en high: reset wins, nothing starts
        step_clk();
        step_clk();
        chk_idle("reset");
        rst = 1'b0;
        en = 1'b0;
        step_clk();
        chk_idle("idle");

        run_seq("gt_w4", 8'h00, 12'd4, 4, 16'd200, 16'd100, 1'b0, 8'hFF, -1);

        // DONE holds the result while en stays low
        for (int i = 0; i < 3; i++) begin
            step_clk();
            chk($sformatf("hold ready %0d", i), 32'(ready), 32'd1);
            chk($sformatf("hold response %0d", i), 32'(response), 32'hFF);
        end

        // Restart from DONE (ready drops at once); stray en mid-run ignored
        run_seq("tie_w4", 8'h00, 12'd4, 4, 16'd100, 16'd100, 1'b0, 8'h00, 9);

        run_seq("par_w1", 8'h00, 12'd1, 1, 16'd0, 16'd150, 1'b1, 8'hAA, -1);

        run_seq("w0", 8'h00, 12'd0, 1, 16'd200, 16'd100, 1'b0, 8'hFF, -1);

        // Challenge 8'h84 steps to 8'h09: equal selects, B forced to A^1
        en = 1'b1;
        chall_in = 8'h84;
        window = 12'd4;
        step_clk();
        en = 1'b0;
        chk("eq sel_a", 32'(sel_a), 32'd1);
        chk("eq sel_b", 32'(sel_b), 32'd0);
        chk("eq cnt_clr", 32'(cnt_clr), 32'd1);

        // Advance to round 3, second RUN cycle, then reset
        for (int i = 0; i < 20; i++) step_clk();
        chk("mid osc_en", 32'(osc_en), 32'd1);
        chk("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        chk_idle("midrst");

        run_seq("after_rst", 8'h00, 12'd4, 4, 16'd200, 16'd100, 1'b0, 8'hFF, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_sequencer.md
PUF_SEQUENCER -- requirements
Module: puf_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of each oscillator edge count.
REQ-002 Parameter WIN_W, default 12: width of the measurement-window length.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  start request; sampled in IDLE or DONE.
REQ-006 chall_in  input  8  challenge; captured on an accepted start.
REQ-007 window  input  WIN_W  oscillator run length in cycles; captured on an accepted start.
REQ-008 cnt_a  input  CNT_W  edge count of the oscillator selected by sel_a.
REQ-009 cnt_b  input  CNT_W  edge count of the oscillator selected by sel_b.
REQ-010 osc_en  output  1  oscillator/counter enable.
REQ-011 cnt_clr  output  1  counter clear pulse.
REQ-012 sel_a  output  3  mux select, oscillator A.
REQ-013 sel_b  output  3  mux select, oscillator B.
REQ-014 response  output  8  assembled response.
REQ-015 ready  output  1  response valid.
REQ-016 busy  output  1  sequence in progress.

Function
REQ-017 States: IDLE, CLEAR, RUN, SAMPLE, DONE; encoding one-hot or binary, implementer's choice.
REQ-018 Accepted start: en=1 in IDLE or DONE -> capture chall_in into the LFSR (8'h00 replaced by 8'h01), capture window (0 treated as 1), zero round counter and response, clear ready, go to CLEAR.
REQ-019 LFSR: 8-bit Fibonacci; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; steps exactly once on each entry into CLEAR.
REQ-020 Selects: sel_a = lfsr[2:0], sel_b = lfsr[5:3] of the stepped value; if equal, sel_b = sel_a ^ 3'b001; both held constant from CLEAR through SAMPLE of the round.
REQ-021 CLEAR lasts 1 cycle: cnt_clr=1, osc_en=0; then RUN.
REQ-022 RUN lasts exactly window cycles: osc_en=1, cnt_clr=0; internal down-counter, no wrap; then SAMPLE.
REQ-023 SAMPLE lasts 1 cycle: osc_en=0; bit = (cnt_a > cnt_b), ties give 0; response <= {response[6:0], bit} (round 0 ends in MSB); round counter increments.
REQ-024 After SAMPLE of round 7 -> DONE; otherwise -> CLEAR.
REQ-025 DONE: ready=1, response held stable; en=0 -> stay; en=1 -> restart per REQ-018.
REQ-026 busy=1 in CLEAR, RUN, SAMPLE; en, chall_in and window ignored while busy.
REQ-027 Latency: from the edge accepting start to the first cycle with ready=1 is 8*(W+2)+1 cycles, where W is the effective window.
REQ-028 cnt_a/cnt_b used only in SAMPLE; no saturation handling inside the block.

Reset
REQ-029 rst=1 at any edge, including mid-run -> IDLE; osc_en=0, cnt_clr=0, sel_a=0, sel_b=0, response=8'h00, ready=0, busy=0, LFSR=8'h01, round and window counters 0.
REQ-030 rst dominates a simultaneous en=1; no start accepted on that edge.

Structure
REQ-031 Shared package puf_pkg holds the state enumeration, LFSR tap constant, and default CNT_W/WIN_W values.
REQ-032 One sub-module, puf_lfsr8 (load, step, seed-zero substitution), is natural; FSM, counters and shift register stay in puf_sequencer.

Verification
REQ-033 rst, then en pulse, chall_in=8'h00, window=4, cnt_a=200, cnt_b=100 fixed -> first CLEAR sel_a=2, sel_b=0; response=8'hFF; ready rises 49 cycles after the start edge.
REQ-034 Same, cnt_a=100, cnt_b=100 -> response=8'h00 (tie gives 0).
REQ-035 Bench returns cnt_a>cnt_b only in even rounds, window=1 -> response=8'hAA; each RUN lasts exactly 1 cycle, with one cnt_clr pulse per round.
REQ-036 window=0 -> behaves as window=1; 8 rounds, ready rises 25 cycles after start.
REQ-037 rst asserted in round 3 RUN -> next cycle IDLE, all outputs at reset values; en pulse during a run is ignored; new start from DONE clears ready for the next cycle and reruns.
REQ-038 Every round: sel_a != sel_b, selects stable from CLEAR through SAMPLE, osc_en never overlaps cnt_clr.
